axi_stream_frame_packer: RTL and testbench
==========================================

# axi_stream_frame_packer

Frame transmitter for the pipeline's AXI4-Stream image framing protocol: beat 0 = X size, beat 1 = Y size, then X×Y pixel beats, tlast on the final beat. Accepts a bare pixel stream plus per-frame dimensions and emits a correctly framed stream. It sits upstream of the filter stages (e.g. the Sobel stage), which parse exactly this format.

## Interface
- DATA_W, 24, stream data width; header beats and pixels both use it
- SIZE_W, 13, width of frame dimensions
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  frame request; sampled only in IDLE
- xsize_i  in  SIZE_W  pixels per line; latched on accepted start
- ysize_i  in  SIZE_W  lines per frame; latched on accepted start
- busy_o  out  1  high from accepted start until the final beat handshake
- done_o  out  1  one-cycle pulse after the final beat handshake
- s_tvalid_i  in  1  pixel valid
- s_tready_o  out  1  pixel ready
- s_tdata_i  in  DATA_W  pixel data, passed unmodified
- m_tvalid_o  out  1  framed stream valid
- m_tready_i  in  1  framed stream ready
- m_tlast_o  out  1  last beat of frame
- m_tdata_o  out  DATA_W  header or pixel data

## Operation
- States: IDLE, YSIZE, PIXEL, DRAIN.
- Output register (valid/data/last). Slot free = !m_tvalid_o || m_tready_i. Data loads only when the slot is free. Data/last hold stable while valid && !ready.
- IDLE: start_i=1 latches the sizes, loads the X beat (zero-extended xsize), sets busy_o and moves to YSIZE. start_i outside IDLE is ignored.
- YSIZE: when the slot is free, load the Y beat (zero-extended ysize).
  - If xsize==0 or ysize==0, the Y beat has m_tlast_o=1 and the state moves to DRAIN. The frame is header only.
  - Otherwise the state moves to PIXEL.
- PIXEL: s_tready_o = slot free (combinational from m_tready_i). Each s_tvalid_i && s_tready_o handshake loads the pixel.
  - Column counter runs 0..xsize-1 and wraps. Row counter increments on wrap.
  - m_tlast_o=1 on the pixel where col==xsize-1 && row==ysize-1. On that pixel the state moves to DRAIN.
- DRAIN: when m_tvalid_o && m_tready_i, go to IDLE, clear busy_o and pulse done_o next cycle.
- s_tready_o=0 in IDLE, YSIZE and DRAIN. Extra input pixels are never consumed.
- Counters use SIZE_W bits. No multiplier; the counters cover frames up to (2^SIZE_W-1)² pixels.
- Reset, including mid-frame: state IDLE; m_tvalid_o, m_tlast_o, m_tdata_o, s_tready_o, busy_o, done_o, counters and latched sizes all 0. A partial frame is abandoned with no tlast.

## Timing
- start_i at edge k → m_tvalid_o=1 with X beat from cycle k+1.
- With m_tready_i held high: Y beat at k+2. Pixels follow one per cycle, each 1 cycle after its input handshake.
- Full throughput is 1 beat/cycle. There are no bubbles between header and pixels when s_tvalid_i is already high.
- The done_o pulse occurs in the cycle after the tlast handshake. start_i is accepted in that same cycle, because the state is already IDLE.
- Simultaneous output drain and input load in one cycle is legal; the register is replaced.
- m_tready_i low: no loads and no counter advance; the output holds.

## Structure
- Shared package axi_stream_pkg holds:
  - the frame state enum (IDLE/YSIZE/PIXEL/DRAIN)
  - SIZE_W default
  - a header-beat index constant shared with the framing parsers
- Natural sub-module: axi_stream_out_reg, a single-stage valid/ready register slice with last. The packer FSM drives its load enable and input mux.

## Test plan
- Frame xsize=3, ysize=2, pixels 0x11..0x16, m_tready_i=1 → beats 3,2,0x11..0x16; tlast only on 0x16; done_o one cycle after; 8 beats total.
- Same frame, m_tready_i toggled 1,0,0,1 repeating → identical beat sequence. Data is stable while stalled. No pixel is lost or duplicated.
- Gaps in s_tvalid_i during PIXEL → m_tvalid_o deasserts in the gap cycles. Counters stay frozen. tlast is still on pixel 6.
- xsize=0, ysize=5 → two beats (0, 5) with tlast on the second. s_tready_o never asserts. done_o pulses.
- start_i pulsed in YSIZE/PIXEL with different sizes → ignored. Frame uses the originally latched sizes.
- rst_n_i asserted after pixel 2 of a 4×4 frame → all outputs 0 immediately. A new start then produces a clean frame beginning with the X beat.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// -----------------------------------------------------------------------------
// axi_stream_pkg
// Definitions shared by the image-framing blocks: the frame packer here and
// the framing parsers in the downstream filter stages.
//   frame_state_e  : frame transmitter states
//   SIZE_W_DEFAULT : default width of the frame dimension fields
//   HDR_*          : positions of the header beats within a frame
// -----------------------------------------------------------------------------
package axi_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    YSIZE = 2'd1,
    PIXEL = 2'd2,
    DRAIN = 2'd3
  } frame_state_e;

  localparam int SIZE_W_DEFAULT = 13;

  // Beat 0 carries X size, beat 1 carries Y size, pixels start at HDR_BEATS.
  localparam int HDR_X_IDX = 0;
  localparam int HDR_Y_IDX = 1;
  localparam int HDR_BEATS = 2;

endpackage

// File: rtl/axi_stream_out_reg.sv
// -----------------------------------------------------------------------------
// axi_stream_out_reg
// Single-stage valid/ready register slice carrying data and last.
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   load_i             capture data_i/last_i (only assert while free_o)
//   data_i, last_i     beat to capture
//   ready_i            downstream ready
//   valid_o, data_o, last_o  registered beat
//   free_o             slot can accept a new beat this cycle
// -----------------------------------------------------------------------------
module axi_stream_out_reg #(
  parameter int DATA_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              free_o
);

  // The slot is free when empty or when its current beat leaves this cycle,
  // so a drain and a reload may happen on the same edge.
  assign free_o = !valid_o || ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      last_o  <= last_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_stream_frame_packer.sv
// -----------------------------------------------------------------------------
// axi_stream_frame_packer
// Wraps a bare pixel stream into the image framing format:
// X size beat, Y size beat, X*Y pixel beats, tlast on the final beat.
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   start_i, xsize_i, ysize_i frame request and dimensions (sampled in IDLE)
//   busy_o, done_o            frame in progress / one-cycle completion pulse
//   s_tvalid_i/s_tready_o/s_tdata_i            pixel input stream
//   m_tvalid_o/m_tready_i/m_tlast_o/m_tdata_o  framed output stream
// -----------------------------------------------------------------------------
module axi_stream_frame_packer
  import axi_stream_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int SIZE_W = SIZE_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [SIZE_W-1:0] xsize_i,
  input  logic [SIZE_W-1:0] ysize_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              s_tvalid_i,
  output logic              s_tready_o,
  input  logic [DATA_W-1:0] s_tdata_i,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              m_tlast_o,
  output logic [DATA_W-1:0] m_tdata_o
);

  frame_state_e      state_q, state_d;
  logic [SIZE_W-1:0] xsize_q, ysize_q;
  logic [SIZE_W-1:0] col_q, row_q;
  logic              slot_free;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              pix_hs;
  logic              col_end;
  logic              row_end;
  logic              frame_end;

  axi_stream_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (load),
    .data_i  (load_data),
    .last_i  (load_last),
    .ready_i (m_tready_i),
    .valid_o (m_tvalid_o),
    .data_o  (m_tdata_o),
    .last_o  (m_tlast_o),
    .free_o  (slot_free)
  );

  assign col_end = (col_q == xsize_q - SIZE_W'(1));
  assign row_end = (row_q == ysize_q - SIZE_W'(1));

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    s_tready_o = 1'b0;
    pix_hs     = 1'b0;
    frame_end  = 1'b0;
    case (state_q)
      // The slot is always empty in IDLE, so the X beat loads straight from
      // the input port rather than from the size register.
      IDLE: begin
        if (start_i) begin
          load      = 1'b1;
          load_data = DATA_W'(xsize_i);
          state_d   = YSIZE;
        end
      end
      // A zero dimension makes the Y beat the final beat of the frame.
      YSIZE: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = DATA_W'(ysize_q);
          load_last = (xsize_q == '0) || (ysize_q == '0);
          state_d   = load_last ? DRAIN : PIXEL;
        end
      end
      PIXEL: begin
        s_tready_o = slot_free;
        pix_hs     = s_tvalid_i && slot_free;
        if (pix_hs) begin
          load      = 1'b1;
          load_data = s_tdata_i;
          load_last = col_end && row_end;
          if (load_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (m_tvalid_o && m_tready_i) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      xsize_q <= '0;
      ysize_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= frame_end;
      if (state_q == IDLE && start_i) begin
        xsize_q <= xsize_i;
        ysize_q <= ysize_i;
        col_q   <= '0;
        row_q   <= '0;
        busy_o  <= 1'b1;
      end else if (frame_end) begin
        busy_o <= 1'b0;
      end
      // Column wraps at xsize-1; rows advance on each wrap.
      if (pix_hs) begin
        if (col_end) begin
          col_q <= '0;
          row_q <= row_q + SIZE_W'(1);
        end else begin
          col_q <= col_q + SIZE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_frame_packer
// Directed bench for the frame packer: drives sized frames of pixels
// 0x11, 0x12, ... and compares the framed output against expected beats.
// -----------------------------------------------------------------------------
module tb_axi_stream_frame_packer;

  localparam int DATA_W = 24;
  localparam int SIZE_W = 13;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              start_i = 1'b0;
  logic [SIZE_W-1:0] xsize_i = '0;
  logic [SIZE_W-1:0] ysize_i = '0;
  logic              busy_o, done_o;
  logic              s_tvalid_i = 1'b0;
  logic              s_tready_o;
  logic [DATA_W-1:0] s_tdata_i = '0;
  logic              m_tvalid_o;
  logic              m_tready_i = 1'b0;
  logic              m_tlast_o;
  logic [DATA_W-1:0] m_tdata_o;

  axi_stream_frame_packer #(.DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .xsize_i    (xsize_i),
    .ysize_i    (ysize_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .s_tvalid_i (s_tvalid_i),
    .s_tready_o (s_tready_o),
    .s_tdata_i  (s_tdata_i),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .m_tlast_o  (m_tlast_o),
    .m_tdata_o  (m_tdata_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DATA_W:0] out_q[$];
  int              hs_cyc[$];
  int              done_cnt, done_cyc, stall_err, bubbles;
  bit              tready_seen, take, prev_stall, prev_last;
  logic [DATA_W-1:0] prev_data;

  int  idx, pix_n;
  bit  src_en, gap_mode, ready_mode;
  int  start_cyc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor: looks at the bus mid-cycle, where values are those the next
  // rising edge will sample.
  initial forever begin
    @(negedge clk_i);
    if (!rst_n_i) begin
      take       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      take = s_tvalid_i && s_tready_o;
      if (m_tvalid_o && m_tready_i) begin
        out_q.push_back({m_tlast_o, m_tdata_o});
        hs_cyc.push_back(cyc);
      end
      if (prev_stall && (!m_tvalid_o || m_tdata_o !== prev_data || m_tlast_o !== prev_last))
        stall_err++;
      prev_stall = m_tvalid_o && !m_tready_i;
      prev_data  = m_tdata_o;
      prev_last  = m_tlast_o;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (s_tready_o) tready_seen = 1'b1;
      if (busy_o && !m_tvalid_o) bubbles++;
    end
  end

  // Pixel source and downstream ready driver, updated just after each edge.
  initial forever begin
    @(posedge clk_i);
    #1;
    if (!rst_n_i) begin
      s_tvalid_i = 1'b0;
      idx        = 0;
    end else begin
      if (take) idx++;
      if (!src_en) s_tvalid_i = 1'b0;
      else if (!s_tvalid_i || take)
        s_tvalid_i = (idx < pix_n) && (!gap_mode || (cyc % 3) != 0);
      s_tdata_i  = DATA_W'(32'h11 + idx);
      m_tready_i = ready_mode ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
    end
  end

  // Runs one frame of xs*ys pixels (two spare pixels offered), optionally
  // pulsing start with other sizes mid-frame, then checks every beat.
  task automatic applyStimulus(input string name, input int xs, input int ys,
                               input bit rdy_toggle, input bit gaps, input bit inject);
    int n;
    int k;
    logic [DATA_W:0] exp_q[$];
    n = xs * ys;
    @(posedge clk_i);
    #2;
    ready_mode  = rdy_toggle;
    gap_mode    = gaps;
    out_q.delete();
    hs_cyc.delete();
    done_cnt    = 0;
    stall_err   = 0;
    bubbles     = 0;
    tready_seen = 1'b0;
    idx         = 0;
    pix_n       = n + 2;
    src_en      = 1'b1;
    xsize_i     = SIZE_W'(xs);
    ysize_i     = SIZE_W'(ys);
    start_i     = 1'b1;
    start_cyc   = cyc;
    k = 0;
    while (done_cnt == 0 && k < 300) begin
      @(posedge clk_i);
      #2;
      k++;
      start_i = inject && (k == 1 || k == 3);
      xsize_i = 7;
      ysize_i = 7;
    end
    start_i = 1'b0;
    checkOutput({name, "_timeout"}, 32'(done_cnt != 0), 32'd1);

    exp_q.push_back({1'b0, DATA_W'(xs)});
    exp_q.push_back({(xs == 0 || ys == 0), DATA_W'(ys)});
    if (xs != 0 && ys != 0)
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), DATA_W'(32'h11 + i)});

    checkOutput({name, "_beatCount"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      checkOutput($sformatf("%s_beat%0d", name, i), 32'(out_q[i]), 32'(exp_q[i]));
    if (out_q.size() > 0)
      checkOutput({name, "_doneDelay"}, 32'(done_cyc - hs_cyc[hs_cyc.size() - 1]), 32'd1);
    checkOutput({name, "_consumed"}, 32'(idx), (xs == 0 || ys == 0) ? 32'd0 : 32'(n));

    repeat (3) @(posedge clk_i);
    #2;
    checkOutput({name, "_doneOnce"}, 32'(done_cnt), 32'd1);
    checkOutput({name, "_idleBusy"}, {31'd0, busy_o}, 32'd0);
    checkOutput({name, "_idleValid"}, {31'd0, m_tvalid_o}, 32'd0);
    src_en = 1'b0;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_valid"},  {31'd0, m_tvalid_o}, 32'd0);
    checkOutput({name, "_last"},   {31'd0, m_tlast_o},  32'd0);
    checkOutput({name, "_data"},   32'(m_tdata_o),      32'd0);
    checkOutput({name, "_sready"}, {31'd0, s_tready_o}, 32'd0);
    checkOutput({name, "_busy"},   {31'd0, busy_o},     32'd0);
    checkOutput({name, "_done"},   {31'd0, done_o},     32'd0);
  endtask

  initial begin
    int k;
    src_en = 1'b0;
    ready_mode = 1'b0;
    gap_mode = 1'b0;
    pix_n = 0;
    repeat (3) @(posedge clk_i);
    #2;
    checkResetOutputs("reset");
    rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // Full-throughput 3x2 frame: back-to-back beats, X beat one cycle after start.
    applyStimulus("basic", 3, 2, 1'b0, 1'b0, 1'b0);
    checkOutput("basic_xLatency", 32'(hs_cyc[0] - start_cyc), 32'd1);
    checkOutput("basic_contiguous", 32'(hs_cyc[7] - hs_cyc[0]), 32'd7);
    checkOutput("basic_bubbles", 32'(bubbles), 32'd0);

    // Downstream ready toggling 1,0,0,1: same beats, data stable while stalled.
    applyStimulus("stall", 3, 2, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_stable", 32'(stall_err), 32'd0);

    // Input valid gaps: output valid drops in the gaps.
    applyStimulus("gaps", 3, 2, 1'b0, 1'b1, 1'b0);
    checkOutput("gaps_bubbles", 32'(bubbles != 0), 32'd1);

    // Zero-width frame: header only, no pixel accepted.
    applyStimulus("zero", 0, 5, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_tready", {31'd0, tready_seen}, 32'd0);

    // Start pulses mid-frame with other sizes must be ignored.
    applyStimulus("ignore", 3, 2, 1'b0, 1'b0, 1'b1);

    // Mid-frame reset of a 4x4 frame after pixel 2.
    @(posedge clk_i);
    #2;
    out_q.delete();
    hs_cyc.delete();
    idx = 0;
    pix_n = 18;
    src_en = 1'b1;
    ready_mode = 1'b0;
    gap_mode = 1'b0;
    xsize_i = 4;
    ysize_i = 4;
    start_i = 1'b1;
    @(posedge clk_i);
    #2;
    start_i = 1'b0;
    k = 0;
    while (out_q.size() < 4 && k < 50) begin
      @(posedge clk_i);
      #2;
      k++;
    end
    checkOutput("midReset_reach", 32'(out_q.size() >= 4), 32'd1);
    rst_n_i = 1'b0;
    src_en = 1'b0;
    #1;
    checkResetOutputs("midReset");
    repeat (2) @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    applyStimulus("afterReset", 3, 2, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
